keypad_matrix_scanner: RTL and testbench

Parametrised successor to the fixed 4x4 keypad scanner. It drives an active-low one-hot row strobe, samples active-low column returns, debounces per scan frame, and emits one encoded key event per press on a valid/ready interface. It sits between the FPGA keypad pins and the tone-selection logic of the beeper music player. It replaces the free-running `fn`-edge latch with a clocked handshake, an overrun flag and optional auto-repeat.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/keypad_scan_timer.sv | 53 +++++
 rtl/keypad_matrix_scanner.sv | 185 ++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, "no key" sentinel and code-width helper
// for keypad_matrix_scanner.
package keypad_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_DOWN
    } kp_state_e;

    // Candidates carry one extra MSB; when set it means "no key pressed", which
    // also makes "none" compare above every real code.
    localparam logic KP_NONE_FLAG = 1'b1;

    function automatic int kp_code_w(input int rows, input int cols);
        return (rows * cols > 2) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: row-dwell divider, tick pulse, row index, frame-end pulse
// and the registered active-low row strobe; cleared by rst or start low.
module keypad_scan_timer
    import keypad_pkg::*;
#(
    parameter  int ROWS     = 4,
    parameter  int SCAN_DIV = 250000,
    localparam int RW       = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            tick,
    output logic            frame_end,
    output logic [RW-1:0]   row_idx,
    output logic [ROWS-1:0] row
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div_q;
    logic          running_q;
    logic [RW-1:0] idx_nxt;

    // The divider only runs once a row is actually driven, so the first dwell is full length.
    assign tick      = running_q && start && (div_q == DW'(SCAN_DIV - 1));
    assign frame_end = tick && (row_idx == RW'(ROWS - 1));

    always_comb begin
        idx_nxt = row_idx;
        if (tick) begin
            idx_nxt = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
        end
    end

    // NOTE: rst is synchronous and start low shares the same clear path; state uses <= only.
    always_ff @(posedge clk) begin
        if (rst || !start) begin
            div_q     <= '0;
            running_q <= 1'b0;
            row_idx   <= '0;
            row       <= '1;
        end else begin
            running_q <= 1'b1;
            if (running_q) begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end
            row_idx <= idx_nxt;
            row     <= ~(ROWS'(1) << idx_nxt);
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a ROWSxCOLS keypad, debounces per frame and emits
// one encoded key event per press on valid/ready. Auto-repeat: KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS         = 4,
    parameter  int COLS         = 4,
    parameter  int SCAN_DIV     = 250000,
    parameter  int DEBOUNCE     = 4,
    parameter  int REPEAT_DELAY = 50,
    parameter  int REPEAT_RATE  = 10,
    localparam int KW           = kp_code_w(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [COLS-1:0] column,
    output logic [ROWS-1:0] row,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overrun
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = KW + 1;
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CAND_NONE = {KP_NONE_FLAG, {KW{1'b0}}};

    if (ROWS < 2 || COLS < 2 || SCAN_DIV < 2 || DEBOUNCE < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_matrix_scanner: parameter out of range");
    end

    logic          tick;
    logic          frame_end;
    logic [RW-1:0] row_idx;

    keypad_scan_timer #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .frame_end (frame_end),
        .row_idx   (row_idx),
        .row       (row)
    );

    logic [CW-1:0] row_cand, frame_cand, cur_cand_q, prev_cand_q;
    logic [SW-1:0] stable_q, stable_nxt;
    logic          stable_hit;
    kp_state_e     state_q, state_d;
    logic [KW-1:0] held_code_q, held_code_d;
    logic          emit;
    logic [KW-1:0] emit_code;
    logic          rep_fire;

    // Lowest pressed column wins; rows are scanned in ascending order so min() keeps the lowest code.
    always_comb begin
        row_cand = CAND_NONE;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!column[c]) row_cand = {1'b0, KW'(int'(row_idx) * COLS + c)};
        end
        frame_cand = (row_cand < cur_cand_q) ? row_cand : cur_cand_q;
    end

    always_comb begin
        if (frame_cand != prev_cand_q)      stable_nxt = SW'(1);
        else if (stable_q == SW'(DEBOUNCE)) stable_nxt = stable_q;
        else                                stable_nxt = stable_q + 1'b1;
    end

    assign stable_hit = (stable_nxt == SW'(DEBOUNCE));

    always_ff @(posedge clk) begin
        if (rst || !start) begin
            cur_cand_q  <= CAND_NONE;
            prev_cand_q <= CAND_NONE;
            stable_q    <= '0;
        end else if (frame_end) begin
            cur_cand_q  <= CAND_NONE;
            prev_cand_q <= frame_cand;
            stable_q    <= stable_nxt;
        end else if (tick) begin
            cur_cand_q  <= frame_cand;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW    = $clog2(RP_MAX + 1);

    logic [RPW-1:0] rep_cnt_q, rep_cnt_inc;
    logic           rep_phase_q;
    logic           same_hold;

    assign same_hold   = frame_end && (state_q == ST_DOWN) && stable_hit && !frame_cand[KW] &&
                         (frame_cand[KW-1:0] == held_code_q);
    assign rep_cnt_inc = rep_cnt_q + 1'b1;
    assign rep_fire    = same_hold &&
                         (rep_cnt_inc == (rep_phase_q ? RPW'(REPEAT_RATE) : RPW'(REPEAT_DELAY)));

    // Counter restarts on every fresh accept and whenever the FSM is not holding a key.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_DOWN || (emit && !rep_fire)) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b1;
        end else if (same_hold) begin
            rep_cnt_q   <= rep_cnt_inc;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        emit        = 1'b0;
        emit_code   = frame_cand[KW-1:0];
        if (!start) begin
            state_d = ST_IDLE;
        end else if (frame_end && stable_hit) begin
            case (state_q)
                ST_IDLE: begin
                    if (!frame_cand[KW]) begin
                        state_d     = ST_DOWN;
                        held_code_d = frame_cand[KW-1:0];
                        emit        = 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (frame_cand[KW]) begin
                        state_d = ST_IDLE;
                    end else if (frame_cand[KW-1:0] != held_code_q) begin
                        held_code_d = frame_cand[KW-1:0];
                        emit        = 1'b1;
                    end else if (rep_fire) begin
                        emit = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            held_code_q <= '0;
        end else begin
            state_q     <= state_d;
            held_code_q <= held_code_d;
        end
    end

    assign key_held = (state_q == ST_DOWN);

    // An event may replace a pending one only when that one is being accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || key_ready) begin
                key_code  <= emit_code;
                key_valid <= 1'b1;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: keypad matrix model, event
// scoreboard and per-scenario tasks; repeat checks follow KEYPAD_REPEAT_EN.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = ROWS * SCAN_DIV;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            key_ready;
    logic [COLS-1:0] column;
    logic [ROWS-1:0] row;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;
    logic            overrun;

    logic [15:0]     pressed;
    logic [3:0]      exp_q[$];
    logic [3:0]      exp_code;
    int              errors = 0;
    int              checks = 0;
    int              events = 0;
    int unsigned     cyc = 0;
    int unsigned     e0 = 0;

    keypad_matrix_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .column    (column),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        column = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < COLS; c++) begin
                    if (pressed[r * COLS + c]) column[c] = 1'b0;
                end
            end
        end
    end

    // Scoreboard: a transfer happens on the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (key_valid === 1'b1 && key_ready === 1'b1) begin
            events++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got code %0d, no event expected (t=%0t)", key_code, $time);
            end else begin
                exp_code = exp_q.pop_front();
                if (key_code !== exp_code) begin
                    errors++;
                    $display("FAIL event_code: got %0d, expected %0d (t=%0t)", key_code, exp_code, $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        cycles(n * FRAME);
    endtask

    task automatic align_frame();
        while ((cyc - e0) % FRAME != 0) cycles(1);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Press from a frame boundary and check the event appears exactly after DEBOUNCE frames.
    task automatic press_and_wait(input logic [15:0] mask, input logic [3:0] code, input string name);
        pressed = mask;
        cycles(DEBOUNCE * FRAME - 1);
        chk({name, "_early_valid"}, 32'(key_valid), 32'd0);
        cycles(1);
        chk({name, "_valid"}, 32'(key_valid), 32'd1);
        chk({name, "_code"}, 32'(key_code), 32'(code));
        chk({name, "_held"}, 32'(key_held), 32'd1);
    endtask

    task automatic release_keys(input string name);
        pressed = '0;
        frames(DEBOUNCE);
        chk({name, "_released"}, 32'(key_held), 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key_ready = 1'b0; pressed = '0;
        cycles(3);
        chk("rst_row", 32'(row), 32'hF);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        key_ready = 1'b1;
        cycles(2);
        chk("idle_row", 32'(row), 32'hF);
    endtask

    task automatic test_row_scan();
        logic [3:0] exp_row;
        start = 1'b1;
        cycles(1);
        e0 = cyc;
        for (int k = 0; k < FRAME; k++) begin
            exp_row = ~(4'b0001 << (k / SCAN_DIV));
            chk("row_scan", 32'(row), 32'(exp_row));
            cycles(1);
        end
    endtask

    task automatic test_single_press();
        int ev0 = events;
        exp_q.push_back(4'd6);
        press_and_wait(16'h0040, 4'd6, "single");
        frames(4);
        chk("single_still_held", 32'(key_held), 32'd1);
        chk("single_no_repeat_valid", 32'(key_valid), 32'd0);
        release_keys("single");
        chk("single_event_count", 32'(events - ev0), 32'd1);
    endtask

    task automatic test_bounce();
        int ev0 = events;
        for (int i = 0; i < 4; i++) begin
            pressed = 16'h0040;
            frames(1);
            pressed = '0;
            frames(1);
        end
        chk("bounce_not_held", 32'(key_held), 32'd0);
        chk("bounce_no_event", 32'(events - ev0), 32'd0);
        exp_q.push_back(4'd6);
        press_and_wait(16'h0040, 4'd6, "bounce");
        release_keys("bounce");
    endtask

    task automatic test_multi_key();
        exp_q.push_back(4'd3);
        press_and_wait(16'h0208, 4'd3, "multi");
        release_keys("multi");
    endtask

    task automatic test_overrun();
        key_ready = 1'b0;
        exp_q.push_back(4'd6);
        press_and_wait(16'h0040, 4'd6, "ovr_first");
        chk("ovr_not_yet", 32'(overrun), 32'd0);
        release_keys("ovr_first");
        pressed = 16'h0200;
        frames(DEBOUNCE);
        chk("ovr_code_kept", 32'(key_code), 32'd6);
        chk("ovr_valid_kept", 32'(key_valid), 32'd1);
        chk("ovr_set", 32'(overrun), 32'd1);
        key_ready = 1'b1;
        cycles(1);
        chk("ovr_valid_drop", 32'(key_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        align_frame();
        release_keys("ovr_second");
    endtask

    task automatic test_repeat_and_stop();
        logic want;
        exp_q.push_back(4'd5);
`ifdef KEYPAD_REPEAT_EN
        repeat (3) exp_q.push_back(4'd5);
`endif
        press_and_wait(16'h0020, 4'd5, "repeat");
        for (int f = DEBOUNCE + 1; f <= 15; f++) begin
            frames(1);
`ifdef KEYPAD_REPEAT_EN
            want = (f == 11 || f == 13 || f == 15);
`else
            want = 1'b0;
`endif
            chk($sformatf("repeat_frame%0d_valid", f), 32'(key_valid), 32'(want));
        end
        cycles(5);
        start = 1'b0;
        cycles(1);
        chk("stop_row", 32'(row), 32'hF);
        chk("stop_held", 32'(key_held), 32'd0);
        chk("stop_valid", 32'(key_valid), 32'd0);
        pressed = '0;
        cycles(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_reset_clears();
        rst = 1'b1;
        cycles(1);
        chk("rst_clears_overrun", 32'(overrun), 32'd0);
        chk("rst_clears_valid", 32'(key_valid), 32'd0);
        rst = 1'b0;
        cycles(1);
    endtask

    initial begin
        test_reset();
        test_row_scan();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_repeat_and_stop();
        test_reset_clears();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
